// File: rtl/bs_pkg.sv
// Shared definitions for the packet bitstream decoder: field widths,
// PID encodings and the decoder state encoding.
package bs_pkg;

    localparam int PID_W  = 4;
    localparam int ADDR_W = 7;
    localparam int ENDP_W = 4;
    localparam int DATA_W = 64;
    localparam int CNT_W  = 7;

    typedef enum logic [PID_W-1:0] {
        PID_OUT   = 4'b0001,
        PID_IN    = 4'b1001,
        PID_DATA0 = 4'b0011,
        PID_ACK   = 4'b0010,
        PID_NAK   = 4'b1010
    } pid_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RECV_PID,
        ST_RECV_ADDR,
        ST_RECV_ENDP,
        ST_RECV_DATA,
        ST_HOLD,
        ST_DRAIN
    } dec_state_t;

    // Counter value at which the last bit of a w-bit field is taken.
    function automatic logic [CNT_W-1:0] last_idx(input int w);
        return CNT_W'(w - 1);
    endfunction

endpackage

// File: rtl/bitstream_decoder_if.sv
// Line-side inputs and decoded-packet outputs of the bitstream decoder.
// Handshake: pktready is held high with all fields stable until a posedge
// samples pktack=1; pktready drops on that edge. pktack is ignored otherwise.
interface bitstream_decoder_if;
    import bs_pkg::*;

    logic              inb;
    logic              sending;
    logic              pause;
    logic              pktack;
    logic [PID_W-1:0]  pid;
    logic [ADDR_W-1:0] addr;
    logic [ENDP_W-1:0] endp;
    logic [DATA_W-1:0] data;
    logic              pktready;
    logic              pid_err;
    logic              frame_err;
    dec_state_t        dbg_state;

    modport master (
        output inb, sending, pause, pktack,
        input  pid, addr, endp, data, pktready, pid_err, frame_err, dbg_state
    );

    modport slave (
        input  inb, sending, pause, pktack,
        output pid, addr, endp, data, pktready, pid_err, frame_err, dbg_state
    );

endinterface

// File: rtl/sipo_shiftreg.sv
// Serial-in parallel-out shift register. Bits enter at the MSB end so that
// after W shifts Q[0] holds the first bit received (LSB-first fields).
// clr empties the register; clr together with en loads the bit into a
// freshly cleared register.
module sipo_shiftreg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_L,
    input  logic         en,
    input  logic         clr,
    input  logic         inb,
    output logic [W-1:0] Q
);

    logic [W-1:0] q_d, q_q;

    // Next register contents: clear, shift, or hold.
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = en ? {inb, {(W-1){1'b0}}} : '0;
        end else if (en) begin
            q_d = {inb, q_q[W-1:1]};
        end
    end

    // Register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_L) q_q <= '0;
        else        q_q <= q_d;
    end

    assign Q = q_q;

endmodule

// File: rtl/bitstream_decoder.sv
// Bitstream decoder: reassembles PID, address, endpoint and data fields from
// the unstuffed serial line and presents the packet with a ready/ack handshake.
// Optional macro BS_DEC_PIDCHK_EN: check PID bits 4-7 against ~pid.
module bitstream_decoder
    import bs_pkg::*;
(
    input  logic               clk,
    input  logic               rst_L,
    bitstream_decoder_if.slave bus
);

    dec_state_t        state_d, state_q;
    logic [CNT_W-1:0]  count_d, count_q;
    logic              pktready_d, pktready_q;
    logic              pid_err_d, pid_err_q;
    logic              frame_err_d, frame_err_q;

    logic              take, clr, pid_ok;
    logic              pid_en, addr_en, endp_en, data_en;
    logic [PID_W-1:0]  pid_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ENDP_W-1:0] endp_q;
    logic [DATA_W-1:0] data_q;

    assign take = bus.sending && !bus.pause;

    sipo_shiftreg #(.W(PID_W))  u_pid  (.clk(clk), .rst_L(rst_L), .en(pid_en),  .clr(clr), .inb(bus.inb), .Q(pid_q));
    sipo_shiftreg #(.W(ADDR_W)) u_addr (.clk(clk), .rst_L(rst_L), .en(addr_en), .clr(clr), .inb(bus.inb), .Q(addr_q));
    sipo_shiftreg #(.W(ENDP_W)) u_endp (.clk(clk), .rst_L(rst_L), .en(endp_en), .clr(clr), .inb(bus.inb), .Q(endp_q));
    sipo_shiftreg #(.W(DATA_W)) u_data (.clk(clk), .rst_L(rst_L), .en(data_en), .clr(clr), .inb(bus.inb), .Q(data_q));

`ifdef BS_DEC_PIDCHK_EN
    // PID bits 4-6 are held here; bit 7 is still on the line when checked.
    logic       pidc_en;
    logic [2:0] pidc_q;

    sipo_shiftreg #(.W(3)) u_pidc (.clk(clk), .rst_L(rst_L), .en(pidc_en), .clr(clr), .inb(bus.inb), .Q(pidc_q));

    assign pid_ok = ({bus.inb, pidc_q} == ~pid_q);
`else
    assign pid_ok = 1'b1;
`endif

    // Next-state, counter, field-enable and pulse logic.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        pid_err_d   = 1'b0;
        frame_err_d = 1'b0;
        clr         = 1'b0;
        pid_en      = 1'b0;
        addr_en     = 1'b0;
        endp_en     = 1'b0;
        data_en     = 1'b0;
`ifdef BS_DEC_PIDCHK_EN
        pidc_en     = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (take) begin
                    clr     = 1'b1;
                    pid_en  = 1'b1;
                    count_d = CNT_W'(1);
                    state_d = ST_RECV_PID;
                end
            end
            ST_RECV_PID: begin
                if (!bus.sending) begin
                    frame_err_d = 1'b1;
                    count_d     = '0;
                    state_d     = ST_IDLE;
                end else if (take) begin
                    pid_en = (count_q < CNT_W'(PID_W));
`ifdef BS_DEC_PIDCHK_EN
                    pidc_en = !pid_en && (count_q != last_idx(2*PID_W));
`endif
                    if (count_q == last_idx(2*PID_W)) begin
                        count_d = '0;
                        if (!pid_ok) begin
                            pid_err_d = 1'b1;
                            state_d   = ST_DRAIN;
                        end else begin
                            case (pid_t'(pid_q))
                                PID_OUT, PID_IN: state_d = ST_RECV_ADDR;
                                PID_DATA0:       state_d = ST_RECV_DATA;
                                PID_ACK, PID_NAK: state_d = ST_HOLD;
                                default: begin
                                    pid_err_d = 1'b1;
                                    state_d   = ST_DRAIN;
                                end
                            endcase
                        end
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            ST_RECV_ADDR, ST_RECV_ENDP, ST_RECV_DATA: begin
                if (!bus.sending) begin
                    frame_err_d = 1'b1;
                    count_d     = '0;
                    state_d     = ST_IDLE;
                end else if (take) begin
                    count_d = count_q + CNT_W'(1);
                    if (state_q == ST_RECV_ADDR) begin
                        addr_en = 1'b1;
                        if (count_q == last_idx(ADDR_W)) begin
                            count_d = '0;
                            state_d = ST_RECV_ENDP;
                        end
                    end else if (state_q == ST_RECV_ENDP) begin
                        endp_en = 1'b1;
                        if (count_q == last_idx(ENDP_W)) begin
                            count_d = '0;
                            state_d = ST_HOLD;
                        end
                    end else begin
                        data_en = 1'b1;
                        if (count_q == last_idx(DATA_W)) begin
                            count_d = '0;
                            state_d = ST_HOLD;
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (bus.pktack) state_d = bus.sending ? ST_DRAIN : ST_IDLE;
            end
            ST_DRAIN: begin
                if (!bus.sending) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        pktready_d = (state_d == ST_HOLD);
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_L) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            pktready_q  <= 1'b0;
            pid_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            pktready_q  <= pktready_d;
            pid_err_q   <= pid_err_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign bus.pid       = pid_q;
    assign bus.addr      = addr_q;
    assign bus.endp      = endp_q;
    assign bus.data      = data_q;
    assign bus.pktready  = pktready_q;
    assign bus.pid_err   = pid_err_q;
    assign bus.frame_err = frame_err_q;
    assign bus.dbg_state = state_q;

endmodule

// File: doc/bitstream_decoder.md
# bitstream_decoder

Serial-to-parallel receiver for the packet bitstream. Samples one bit per enabled cycle from the line side (after bit-unstuffing), reassembles the PID, address, endpoint and data fields, and checks the PID complement. Presents the decoded packet to the protocol FSM with a ready/ack handshake. Inverse of the bitstream encoder: field order, widths and bit order match it exactly.

## Interface
Parameters:
- none; field widths come from the shared package.

Ports:
- clk  in  1  single clock; all state changes on posedge
- rst_L  in  1  reset, synchronous, active-low
- inb  in  1  serial data bit
- sending  in  1  frame active; high for every bit of a packet
- pause  in  1  current bit is not valid (stuffed bit); do not sample
- pktack  in  1  consumer has taken the held packet
- pid  out  4  decoded PID (true nibble)
- addr  out  7  token address
- endp  out  4  token endpoint
- data  out  64  DATA0 payload
- pktready  out  1  packet complete; fields stable while high
- pid_err  out  1  one-cycle pulse: bad or unknown PID
- frame_err  out  1  one-cycle pulse: sending dropped mid-field

## Operation
- A bit is taken on a posedge where sending=1 and pause=0. All fields are received LSB first.
- PID field: 8 bits, {~pid, pid}. Bits 0-3 form pid; bits 4-7 must equal ~pid.
- PID dispatch, evaluated after bit 8:
  - OUT 4'b0001 and IN 4'b1001 -> 7 addr bits, then 4 endp bits.
  - DATA0 4'b0011 -> 64 data bits.
  - ACK 4'b0010 and NAK 4'b1010 -> complete.
  - Any other value -> pid_err.
- States:
  - IDLE: on the first valid bit, clear all field registers, shift the bit in, set count=1, go to RECV_PID.
  - RECV_PID: after the 8th bit, dispatch to RECV_ADDR, RECV_DATA or HOLD, or go to DRAIN with pid_err.
  - RECV_ADDR: after 7 bits, go to RECV_ENDP.
  - RECV_ENDP: after 4 bits, go to HOLD.
  - RECV_DATA: after 64 bits, go to HOLD.
  - HOLD: pktready=1. On pktack, go to DRAIN if sending=1, else IDLE. Line bits are ignored while in HOLD.
  - DRAIN: wait for sending=0, then go to IDLE.
- Fields not carried by the packet type read 0.
- sending=0 while in RECV_*:
  - frame_err pulses for one cycle.
  - Go to IDLE; pktready is not raised.
  - Field registers keep their partial contents.
- pause=1 stalls shifting and counting. A stall never causes an error.
- Bit counter: 7 bits, cleared at each field boundary. The last bit of a field is detected when count==width-1 and a valid bit is taken; that bit completes the field.

## Timing
- Reset values: every output and field register 0; state IDLE.
- rst_L low in any state returns the block to IDLE on the next posedge, discarding any partial or held packet.
- pktready rises on the posedge that samples the last bit, so it is visible the cycle after that bit is on the line.
- Handshake: pktready stays high until the posedge where pktack=1 is sampled and drops the following cycle. pktack is ignored outside HOLD.
- pid_err is asserted the cycle after the 8th PID bit is sampled.
- Packet lengths in sampled bits: token 19, data 72, handshake 8.

## Configuration
- BS_DEC_PIDCHK_EN defined: a mismatch between PID bits 4-7 and ~pid raises pid_err and the block enters DRAIN.
- BS_DEC_PIDCHK_EN undefined: bits 4-7 are shifted and discarded. pid_err fires only for unknown PIDs.

## Structure
- Shared package bs_pkg holds:
  - pid_t enum: OUT, IN, DATA0, ACK, NAK.
  - Width constants PID_W=4, ADDR_W=7, ENDP_W=4, DATA_W=64.
  - The decoder state enum.
- One sub-module: sipo_shiftreg #(W), the serial-in parallel-out counterpart of the existing PISO.
  - Ports: en, clr, inb, Q.
  - On en, shifts in at the MSB end so that after W bits Q[0] holds the first bit received.
  - Instantiated once per field.
- The bit counter reuses the existing counter primitive.

## Test plan
- OUT token: bits 1,0,0,0,0,1,1,1 | 1,0,1,1,0,1,1 | 1,0,1,1 with sending=1 -> pktready after 19 bits; pid=0001, addr=1101101, endp=1101, data=0.
- DATA0 with data=64'hDEADBEEF_01234567 and pause=1 on bits 3, 20 and 63 -> pktready after 72 valid bits with data matching; no errors.
- NAK (PID bits 0,1,0,1,1,0,1,0) -> pktready after 8 bits; pid=1010. Holding pktack=0 for 10 cycles keeps the outputs stable; pktack=1 then drops pktready the next cycle.
- PID complement error, pid=0001 with upper nibble 0000:
  - With the macro: pid_err pulse; pktready never rises; DRAIN until sending=0.
  - Without the macro: the packet is accepted as OUT.
- sending drops after 30 DATA0 bits -> frame_err pulse; IDLE; a following ACK packet decodes correctly.
- rst_L=0 while in HOLD -> next cycle pktready=0 and all fields 0.
